// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner and its keypad/datapath neighbours.
// The master side is the scanner itself. The slave side is the keypad and operand consumer.
interface keypad_scanner_if;
    logic [3:0]  rows;
    logic [3:0]  columns;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [13:0] number;
    logic        number_valid;

    modport master (
        input  rows,
        output columns, key_code, key_valid, number, number_valid
    );

    modport slave (
        output rows,
        input  columns, key_code, key_valid, number, number_valid
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce.
// Digit keys are assembled into a decimal operand of up to four digits.
module keypad_scanner #(
    parameter int SCAN_TICKS       = 1000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] NEED_CNT  = CW'(DEBOUNCE_SAMPLES);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;

    logic [3:0]    r_sync1, r_rowsS;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_state, r_col, r_row;
    logic [3:0]    r_pattern;
    logic [CW-1:0] r_count;
    logic [3:0]    r_keyCode;
    logic          r_keyValid;
    logic [13:0]   r_number;
    logic [2:0]    r_digits;
    logic          r_fresh;
    logic          r_numberValid;

    logic          w_sample;
    logic [3:0]    w_lowRows;
    logic          w_oneLow;
    logic [1:0]    w_rowIdx;
    logic [CW-1:0] w_countNext;

    function automatic logic [3:0] keyLookup(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: keyLookup = 4'd1;   4'h1: keyLookup = 4'd2;
            4'h2: keyLookup = 4'd3;   4'h3: keyLookup = 4'd10;
            4'h4: keyLookup = 4'd4;   4'h5: keyLookup = 4'd5;
            4'h6: keyLookup = 4'd6;   4'h7: keyLookup = 4'd11;
            4'h8: keyLookup = 4'd7;   4'h9: keyLookup = 4'd8;
            4'hA: keyLookup = 4'd9;   4'hB: keyLookup = 4'd12;
            4'hC: keyLookup = 4'd14;  4'hD: keyLookup = 4'd0;
            4'hE: keyLookup = 4'd15;  default: keyLookup = 4'd13;
        endcase
    endfunction

    assign w_sample    = (r_tick == LAST_TICK);
    assign w_lowRows   = ~r_rowsS;
    assign w_oneLow    = (w_lowRows != 4'd0) && ((w_lowRows & (w_lowRows - 4'd1)) == 4'd0);
    assign w_countNext = r_count + 1'b1;

    assign kp.columns      = ~(4'b0001 << r_col);
    assign kp.key_code     = r_keyCode;
    assign kp.key_valid    = r_keyValid;
    assign kp.number       = r_number;
    assign kp.number_valid = r_numberValid;

    always_comb begin
        w_rowIdx = 2'd0;
        case (w_lowRows)
            4'b0010: w_rowIdx = 2'd1;
            4'b0100: w_rowIdx = 2'd2;
            4'b1000: w_rowIdx = 2'd3;
            default: w_rowIdx = 2'd0;
        endcase
    end

    // Rows come straight from the keypad, so they are synchronized before any decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'b1111;
            r_rowsS <= 4'b1111;
        end else begin
            r_sync1 <= kp.rows;
            r_rowsS <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_tick <= '0;
        else if (w_sample) r_tick <= '0;
        else               r_tick <= r_tick + 1'b1;
    end

    // One counter serves both press confirmation and release confirmation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_SCAN;
            r_col      <= 2'd0;
            r_row      <= 2'd0;
            r_pattern  <= 4'b1111;
            r_count    <= '0;
            r_keyCode  <= 4'd0;
            r_keyValid <= 1'b0;
        end else begin
            r_keyValid <= 1'b0;
            if (w_sample) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_oneLow) begin
                            r_pattern <= r_rowsS;
                            r_row     <= w_rowIdx;
                            r_count   <= '0;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (r_rowsS == r_pattern) begin
                            if (w_countNext == NEED_CNT) begin
                                r_state    <= ST_PRESSED;
                                r_count    <= '0;
                                r_keyCode  <= keyLookup(r_row, r_col);
                                r_keyValid <= 1'b1;
                            end else begin
                                r_count <= w_countNext;
                            end
                        end else begin
                            r_state <= ST_SCAN;
                            r_col   <= r_col + 2'd1;
                        end
                    end
                    ST_PRESSED: begin
                        if (r_rowsS == 4'b1111) begin
                            if (w_countNext == NEED_CNT) begin
                                r_state <= ST_SCAN;
                                r_count <= '0;
                                r_col   <= r_col + 2'd1;
                            end else begin
                                r_count <= w_countNext;
                            end
                        end else begin
                            r_count <= '0;
                        end
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end
        end
    end

    // After '#' the next digit starts a new operand instead of extending the old one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_number      <= 14'd0;
            r_digits      <= 3'd0;
            r_fresh       <= 1'b0;
            r_numberValid <= 1'b0;
        end else begin
            r_numberValid <= 1'b0;
            if (r_keyValid) begin
                if (r_keyCode <= 4'd9) begin
                    if (r_fresh) begin
                        r_number <= {10'd0, r_keyCode};
                        r_digits <= 3'd1;
                        r_fresh  <= 1'b0;
                    end else if (r_digits < 3'd4) begin
                        r_number <= r_number * 14'd10 + {10'd0, r_keyCode};
                        r_digits <= r_digits + 3'd1;
                    end
                end else if (r_keyCode == 4'd14) begin
                    r_number <= 14'd0;
                    r_digits <= 3'd0;
                    r_fresh  <= 1'b0;
                end else if (r_keyCode == 4'd15) begin
                    r_numberValid <= 1'b1;
                    r_fresh       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model that pulls a row low
// while its key is held and the key's column strobe is low.
module tb_keypad_scanner;
    logic        clk;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  rowsModel;
    int          vecCount;
    int          errCount;
    int          kvCount;
    int          nvCount;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_TICKS(8), .DEBOUNCE_SAMPLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rowsModel = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.columns[c]) rowsModel[r] = 1'b0;
    end
    assign kif.rows = rowsModel;

    always @(negedge clk) begin
        if (kif.key_valid)    kvCount++;
        if (kif.number_valid) nvCount++;
    end

    typedef struct {
        int          keyIdx;
        logic [3:0]  expCode;
        logic [13:0] expNumber;
        bit          expNv;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int keyIdx, output bit seen);
        keys = 16'd1 << keyIdx;
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk);
            if (kif.key_valid) seen = 1'b1;
        end
    endtask

    task automatic waitColumns(input logic [3:0] pattern, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (kif.columns == pattern) seen = 1'b1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_columns"},      kif.columns, 4'b1110);
        checkOutput({tag, "_key_code"},     kif.key_code, 0);
        checkOutput({tag, "_key_valid"},    kif.key_valid, 0);
        checkOutput({tag, "_number"},       kif.number, 0);
        checkOutput({tag, "_number_valid"}, kif.number_valid, 0);
    endtask

    initial begin
        bit          seen;
        int          kvBefore, nvBefore;
        logic [3:0]  lastCode, colsNow;
        logic [3:0]  expCols[5];

        vecCount = 0; errCount = 0; kvCount = 0; nvCount = 0;
        keys = 16'd0;
        reset = 1'b0;

        // key index is row*4+col
        vecs[0]  = '{10, 4'd9,  14'd9,    1'b0};
        vecs[1]  = '{9,  4'd8,  14'd98,   1'b0};
        vecs[2]  = '{12, 4'd14, 14'd0,    1'b0};
        vecs[3]  = '{8,  4'd7,  14'd7,    1'b0};
        vecs[4]  = '{14, 4'd15, 14'd7,    1'b1};
        vecs[5]  = '{0,  4'd1,  14'd1,    1'b0};
        vecs[6]  = '{1,  4'd2,  14'd12,   1'b0};
        vecs[7]  = '{2,  4'd3,  14'd123,  1'b0};
        vecs[8]  = '{4,  4'd4,  14'd1234, 1'b0};
        vecs[9]  = '{5,  4'd5,  14'd1234, 1'b0};
        vecs[10] = '{14, 4'd15, 14'd1234, 1'b1};
        vecs[11] = '{2,  4'd3,  14'd3,    1'b0};
        vecs[12] = '{3,  4'd10, 14'd3,    1'b0};
        vecs[13] = '{15, 4'd13, 14'd3,    1'b0};

        expCols[0] = 4'b1110; expCols[1] = 4'b1101; expCols[2] = 4'b1011;
        expCols[3] = 4'b0111; expCols[4] = 4'b1110;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;

        // Idle rotation: after k posedges the column index is (k/8)%4.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k % 8 == 4) begin
                checkOutput($sformatf("idle_columns_%0d", k), kif.columns, expCols[k/8]);
                checkOutput("idle_key_valid", kif.key_valid, 0);
                checkOutput("idle_number", kif.number, 0);
            end
        end
        checkOutput("idle_kv_count", kvCount, 0);
        checkOutput("idle_nv_count", nvCount, 0);

        // Bounce on '8': seen at one sample point only.
        waitColumns(4'b1101, 40, seen);
        checkOutput("bounce_col1_reached", seen, 1);
        kvBefore = kvCount;
        keys = 16'd1 << 9;
        repeat (10) @(negedge clk);
        keys = 16'd0;
        waitColumns(4'b1011, 30, seen);
        checkOutput("bounce_rotation_resumes", seen, 1);
        checkOutput("bounce_no_key_valid", kvCount - kvBefore, 0);

        // '1' and '4' together on column 0 are rejected.
        kvBefore = kvCount;
        keys = (16'd1 << 0) | (16'd1 << 4);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (kif.columns == 4'b0111) seen = 1'b1;
        end
        keys = 16'd0;
        checkOutput("dual_rotation", seen, 1);
        checkOutput("dual_no_key_valid", kvCount - kvBefore, 0);

        // Long hold of '5' gives a single strobe.
        kvBefore = kvCount;
        keys = 16'd1 << 5;
        lastCode = 4'd0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (kif.key_valid) lastCode = kif.key_code;
        end
        checkOutput("hold5_kv_count", kvCount - kvBefore, 1);
        checkOutput("hold5_code", lastCode, 5);
        keys = 16'd0;
        repeat (48) @(negedge clk);
        colsNow = kif.columns;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (kif.columns != colsNow) seen = 1'b1;
        end
        checkOutput("hold5_scan_resumes", seen, 1);
        applyStimulus(5, seen);
        checkOutput("hold5_second_press", seen, 1);
        keys = 16'd0;
        repeat (48) @(negedge clk);
        checkOutput("hold5_kv_total", kvCount - kvBefore, 2);
        checkOutput("hold5_number_55", kif.number, 55);

        // Reset in the middle of PRESSED for '6'.
        applyStimulus(6, seen);
        checkOutput("rst6_seen", seen, 1);
        checkOutput("rst6_code", kif.key_code, 6);
        repeat (5) @(negedge clk);
        checkOutput("rst6_number_556", kif.number, 556);
        #2 reset = 1'b0;
        #1 checkResetValues("rst6");
        kvBefore = kvCount;
        nvBefore = nvCount;
        repeat (4) @(negedge clk);
        keys = 16'd0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("rst6_no_stale_kv", kvCount - kvBefore, 0);
        checkOutput("rst6_no_nv", nvCount - nvBefore, 0);
        checkOutput("rst6_number_after", kif.number, 0);

        // Reset again so the operand table starts from an empty accumulator.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            kvBefore = kvCount;
            nvBefore = nvCount;
            applyStimulus(vecs[i].keyIdx, seen);
            checkOutput($sformatf("v%0d_key_valid_seen", i), seen, 1);
            checkOutput($sformatf("v%0d_key_code", i), kif.key_code, vecs[i].expCode);
            @(negedge clk);
            checkOutput($sformatf("v%0d_kv_width", i), kif.key_valid, 0);
            checkOutput($sformatf("v%0d_number_valid", i), kif.number_valid, vecs[i].expNv);
            checkOutput($sformatf("v%0d_number", i), kif.number, vecs[i].expNumber);
            @(negedge clk);
            checkOutput($sformatf("v%0d_nv_width", i), kif.number_valid, 0);
            repeat (10) @(negedge clk);
            keys = 16'd0;
            repeat (48) @(negedge clk);
            checkOutput($sformatf("v%0d_kv_count", i), kvCount - kvBefore, 1);
            checkOutput($sformatf("v%0d_nv_count", i), nvCount - nvBefore, vecs[i].expNv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses, and assembles decimal digit keys into a 14-bit operand (0..9999) for the adder datapath. It is the input-side counterpart of the display multiplexer: it drives active-low column strobes one at a time and reads active-low rows. It emits a one-cycle key strobe per debounced press and a one-cycle operand strobe on the enter key.

## Interface
- `SCAN_TICKS`, default 1000: clock cycles each column stays driven; the last cycle of the window is the sample point.
- `DEBOUNCE_SAMPLES`, default 4: consecutive matching sample points needed to accept a press or a release.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `rows`  in  4  keypad rows, active-low, pulled up, asynchronous to `clk`
- `columns`  out  4  column strobes, active-low, exactly one bit low
- `key_code`  out  4  code of the last accepted key
- `key_valid`  out  1  one-cycle pulse per accepted press
- `number`  out  14  accumulated decimal operand
- `number_valid`  out  1  one-cycle pulse when `#` is accepted

## Operation
- Key layout by row r and column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Codes: digits 0..9 map to their value; A=10, B=11, C=12, D=13, *=14, #=15.
- `columns` = ~(1<<col). Sampling uses `rows` after a 2-flop synchronizer (`rows_s`).
- The tick counter runs 0..SCAN_TICKS-1. The sample point is tick == SCAN_TICKS-1. Tick wraps to 0 at every sample point.
- **SCAN**
  - At a sample point, if exactly one bit of `rows_s` is low: capture row and col, clear the stable count, go to DEBOUNCE. The column is held.
  - Otherwise (no row low, or more than one row low): col advances (3 wraps to 0) and the state stays SCAN.
- **DEBOUNCE**
  - At each sample point, if `rows_s` equals the captured pattern, the stable count increments.
  - When the count reaches DEBOUNCE_SAMPLES: go to PRESSED, register `key_code`, and pulse `key_valid`.
  - On a mismatch: return to SCAN and advance col.
- **PRESSED**
  - The column stays held and the release count is cleared on entry.
  - At each sample point: if `rows_s` == 4'b1111 the release count increments, otherwise it clears.
  - When the release count reaches DEBOUNCE_SAMPLES: return to SCAN and advance col.
  - While in PRESSED, no repeat strobe is issued and other keys are ignored.
- **Accumulator**, acting on each `key_valid`:
  - Digit d:
    - If the `fresh` flag is set: `number` = d, digits = 1, clear `fresh`.
    - Else if digits < 4: `number` = number*10 + d, digits+1.
    - Else (digits = 4): ignored.
  - `*`: `number` = 0, digits = 0, clear `fresh`.
  - `#`: pulse `number_valid`; `number` is unchanged; set `fresh`.
  - A..D: no effect on the accumulator.
- Arithmetic: the product is formed in at least 14 bits and is unsigned. The maximum value is 9999, so no overflow is possible.

## Timing
- Reset values:
  - `columns`=4'b1110
  - `key_code`=0, `key_valid`=0
  - `number`=0, `number_valid`=0
  - state SCAN, tick 0, col 0
  - digits 0, `fresh` 0
  - synchronizer flops 4'b1111
- Reset asserted at any time, including mid-DEBOUNCE or mid-PRESSED, forces all of the above immediately. No pulse is emitted on reset deassertion.
- `key_valid` and `key_code` update on the clock edge that ends the accepting sample point. `key_valid` is high for exactly one cycle.
- `number` updates one cycle after `key_valid`.
- `number_valid` is high for exactly one cycle, one cycle after the `key_valid` of `#`.
- Press latency, from a stable press to `key_valid`: 2 sync cycles, plus up to 4*SCAN_TICKS for the scan to reach the column, plus DEBOUNCE_SAMPLES*SCAN_TICKS.
- Column change happens on the edge after a sample point. Rows must settle within SCAN_TICKS-1 cycles.

## Test plan
All scenarios run with SCAN_TICKS=8 and DEBOUNCE_SAMPLES=3. The bench keypad model pulls row r low while its key is pressed and column c is low.
- Reset then idle:
  - `columns` sequence is 1110, 1101, 1011, 0111, 1110, changing every 8 cycles.
  - All other outputs stay 0.
- Hold `5` (r1,c1) for 200 cycles, then release:
  - Exactly one `key_valid` with `key_code`=5.
  - After release plus 3 samples, scanning resumes.
  - A second press gives a second pulse.
- Bounce `8` (low for 1 sample point, then high): no `key_valid`, and `columns` resumes rotation.
- Press 1,2,3,4,5,#:
  - `number` = 1234; the fifth digit is ignored.
  - One `number_valid` pulse with `number`=1234.
  - Then press 3: `number`=3.
- Press 9,8,*,7,#: `number` goes 9 -> 98 -> 0 -> 7, and `number_valid` fires with `number`=7.
- `1` and `4` pressed together (two rows low on c0): ignored, no `key_valid`.
- `reset` asserted during PRESSED of `6`:
  - Outputs return to reset values at once.
  - After release and deassertion, no stale `key_valid`.
